// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_det_pkg
// Description : Shared types and default parameters for the sequence detector.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } seq_state_t;

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter; a clear and an increment in the same
//               cycle yields 1.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_base;

    always_comb begin
        cnt_base = clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (inc && (cnt_base != {CNT_W{1'b1}})) begin
            cnt_d = cnt_base + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : seq_detector
// Description : Serial pattern detector with overlap control, valid qualifier
//               and saturating match counter.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detector
    import seq_det_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in,
    input  logic [WIDTH-1:0] pattern,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             q,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int                  c_FILL_W    = $clog2(WIDTH + 1);
    localparam logic [c_FILL_W-1:0] c_FILL_FULL = c_FILL_W'(WIDTH);

    seq_state_t          state_q, state_d;
    logic [WIDTH-1:0]    hist_q, hist_d;
    logic [c_FILL_W-1:0] fill_q, fill_d;
    logic                q_q, q_d;
    logic                armed_q;

    logic [WIDTH-1:0]    hist_shift;
    logic [c_FILL_W-1:0] fill_inc;
    logic                match;

    generate
        if (WIDTH == 1) begin : g_hist_w1
            assign hist_shift = in;
        end else begin : g_hist_wn
            assign hist_shift = {hist_q[WIDTH-2:0], in};
        end
    endgenerate

    assign fill_inc = (fill_q == c_FILL_FULL) ? c_FILL_FULL : fill_q + 1'b1;

    always_comb begin
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        q_d     = 1'b0;
        match   = 1'b0;
        if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            match  = (fill_inc == c_FILL_FULL) && (hist_shift == pattern);
            q_d    = match;
            // Non-overlap match discards history so the next hit needs WIDTH fresh bits
            if (match && !overlap) begin
                fill_d  = '0;
                state_d = FILL;
            end else if (fill_inc == c_FILL_FULL) begin
                state_d = ARMED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            hist_q  <= '0;
            fill_q  <= '0;
            q_q     <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            q_q     <= q_d;
            armed_q <= (state_d == ARMED);
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_sat_counter (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr),
        .cnt (match_cnt)
    );

    assign q     = q_q;
    assign armed = armed_q;

endmodule : seq_detector
`default_nettype wire

// File: tb/tb_seq_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detector
// Description : Directed and random checks of seq_detector against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detector;

    localparam int W  = 4;
    localparam int CW = 2;
    localparam int c_CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_bit = 1'b0;
    logic [W-1:0]  pattern = 4'b1011;
    logic          overlap = 1'b1;
    logic          cnt_clr = 1'b0;
    logic          q;
    logic [CW-1:0] match_cnt;
    logic          armed;

    int n_checks = 0;
    int n_errors = 0;
    int q_pulses = 0;

    // Reference model: bits received since reset / last non-overlap match
    bit hq[$];
    int m_cnt = 0;
    bit m_q   = 1'b0;

    always #5 clk = ~clk;

    seq_detector #(
        .WIDTH (W),
        .CNT_W (CW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in        (in_bit),
        .pattern   (pattern),
        .overlap   (overlap),
        .cnt_clr   (cnt_clr),
        .q         (q),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        bit hit;
        m_q = 1'b0;
        if (clr) m_cnt = 0;
        if (v) begin
            hq.push_back(b);
            if (hq.size() > W) void'(hq.pop_front());
            if (hq.size() == W) begin
                hit = 1'b1;
                for (int i = 0; i < W; i++) begin
                    if (hq[i] != pattern[W-1-i]) hit = 1'b0;
                end
                if (hit) begin
                    m_q = 1'b1;
                    if (m_cnt < c_CNT_MAX) m_cnt++;
                    if (!overlap) hq.delete();
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit b, input bit clr, input string tag);
        in_valid = v;
        in_bit   = b;
        cnt_clr  = clr;
        model_step(v, b, clr);
        @(posedge clk);
        #1;
        if (q === 1'b1) q_pulses++;
        check({tag, "_q"},     32'(q),         32'(m_q));
        check({tag, "_cnt"},   32'(match_cnt), 32'(m_cnt));
        check({tag, "_armed"}, 32'(armed),     32'(hq.size() == W));
    endtask

    task automatic do_reset(input string tag);
        in_valid = 1'b0;
        cnt_clr  = 1'b0;
        rst      = 1'b0;
        #1;
        check({tag, "_rst_q"},     32'(q),         32'd0);
        check({tag, "_rst_cnt"},   32'(match_cnt), 32'd0);
        check({tag, "_rst_armed"}, 32'(armed),     32'd0);
        hq.delete();
        m_cnt = 0;
        m_q   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic send_stream(input logic [6:0] bits, input string tag);
        for (int i = 6; i >= 0; i--) step(1'b1, bits[i], 1'b0, tag);
    endtask

    initial begin
        #3;
        do_reset("init");

        // Overlapping detection of 1011 in 1011011
        pattern = 4'b1011;
        overlap = 1'b1;
        q_pulses = 0;
        send_stream(7'b1011011, "ovl");
        check("ovl_pulses", 32'(q_pulses), 32'd2);
        check("ovl_final_cnt", 32'(match_cnt), 32'd2);

        // Reset while q is high clears it immediately
        overlap = 1'b0;
        do_reset("midq");
        q_pulses = 0;
        send_stream(7'b1011011, "novl");
        check("novl_pulses", 32'(q_pulses), 32'd1);
        check("novl_final_cnt", 32'(match_cnt), 32'd1);
        check("novl_final_armed", 32'(armed), 32'd0);

        // Idle gaps between valid bits
        do_reset("gap");
        q_pulses = 0;
        begin
            logic [3:0] gbits;
            gbits = 4'b1011;
            for (int i = 3; i >= 0; i--) begin
                step(1'b1, gbits[i], 1'b0, "gapv");
                if (i != 0) for (int j = 0; j < 3; j++) step(1'b0, 1'b0, 1'b0, "gapi");
            end
        end
        step(1'b0, 1'b0, 1'b0, "gap_after");
        check("gap_pulses", 32'(q_pulses), 32'd1);

        // Reset mid-stream discards partial history
        do_reset("mid");
        step(1'b1, 1'b1, 1'b0, "mid_pre");
        step(1'b1, 1'b0, 1'b0, "mid_pre");
        step(1'b1, 1'b1, 1'b0, "mid_pre");
        do_reset("mid");
        step(1'b1, 1'b1, 1'b0, "mid_post");
        check("mid_post1_q", 32'(q), 32'd0);
        step(1'b1, 1'b0, 1'b0, "mid_post");
        step(1'b1, 1'b1, 1'b0, "mid_post");
        check("mid_post3_q", 32'(q), 32'd0);
        step(1'b1, 1'b1, 1'b0, "mid_post");
        check("mid_post4_q", 32'(q), 32'd1);

        // Saturation with all-ones pattern, then clear on a matching cycle
        pattern = 4'b1111;
        overlap = 1'b1;
        do_reset("sat");
        q_pulses = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, "sat");
        check("sat_pulses", 32'(q_pulses), 32'd7);
        check("sat_cnt", 32'(match_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b1, "sat_clr");
        check("sat_clr_cnt", 32'(match_cnt), 32'd1);
        step(1'b0, 1'b0, 1'b1, "clr_only");
        check("clr_only_cnt", 32'(match_cnt), 32'd0);

        // Random soak
        pattern = 4'(($urandom() & 32'h3) | 32'h8);
        do_reset("soak");
        for (int n = 0; n < 1000; n++) begin
            if ($urandom_range(0, 49) == 0) overlap = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 99) == 0) pattern = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) do_reset("soak");
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 15) == 0, "soak");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule : tb_seq_detector
`default_nettype wire

// File: doc/seq_detector.md
# seq_detector

Parametrised serial sequence detector: the next generation of the single-bit `fsm1` detector. It compares a serial bit stream against a run-time programmable pattern of `WIDTH` bits and pulses `q` on each match. It supports overlapping and non-overlapping detection, an input-valid qualifier and a saturating match counter. It sits between a serial input source and the status/logging logic of the lab designs.

## Interface
- `WIDTH`, 4: pattern length in bits, ≥ 1.
- `CNT_W`, 8: width of the match counter, ≥ 1.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (0 = reset). One clock; reset is asynchronous and active-low.
- `in_valid` input 1: `in` carries a valid bit this cycle.
- `in` input 1: serial data bit.
- `pattern` input `WIDTH`: target sequence; `pattern[WIDTH-1]` is the first (oldest) bit received.
- `overlap` input 1: 1 = overlapping detection, 0 = non-overlapping.
- `cnt_clr` input 1: synchronous clear of `match_cnt`.
- `q` output 1: registered one-cycle match pulse.
- `match_cnt` output `CNT_W`: saturating count of matches.
- `armed` output 1: high when at least `WIDTH` bits are accumulated since reset or the last non-overlap match.

## Operation
- Internal state:
  - `hist[WIDTH-1:0]` shift register.
  - `fill` counter in 0..`WIDTH`.
  - Two-state FSM: FILL (`fill < WIDTH`) and ARMED (`fill == WIDTH`).
- Valid cycle (`in_valid=1`):
  - `hist_n = {hist[WIDTH-2:0], in}`. For `WIDTH=1`, `hist_n = in`.
  - `fill_n = min(fill+1, WIDTH)`.
  - `match = (fill_n == WIDTH) && (hist_n == pattern)`.
- On match:
  - `q` goes high.
  - `match_cnt` increments and saturates at 2^`CNT_W`−1.
  - If `overlap=0`, `fill` is forced to 0 and the FSM returns to FILL. The next match needs `WIDTH` fresh bits.
  - If `overlap=1`, `fill` stays at `WIDTH` and the FSM stays ARMED.
- Idle cycle (`in_valid=0`): `hist`, `fill`, the FSM state and `match_cnt` hold, and `q` is 0. Gaps do not break a sequence.
- Transitions:
  - FILL→ARMED when `fill_n == WIDTH` and there is no non-overlap match.
  - ARMED→FILL only on a non-overlap match or on reset.
- `pattern` and `overlap` are sampled on every valid cycle with no internal copy. A change takes effect on the next valid bit, and `hist` is not cleared.
- `cnt_clr`:
  - `cnt_clr` alone: `match_cnt` becomes 0.
  - `cnt_clr` and a match in the same cycle: `match_cnt` becomes 1, because the match is counted after the clear.
  - `cnt_clr` does not affect `q`, `hist` or `fill`.

## Timing
- Reset (`rst=0`, asynchronous): `hist=0`, `fill=0`, FSM in FILL, `q=0`, `match_cnt=0`, `armed=0`.
- Release is synchronous to the next rising edge. The first bit is sampled on the first edge with `rst=1` and `in_valid=1`.
- Latency: `q` is high for exactly one cycle, in the cycle that follows the rising edge that sampled the final pattern bit.
- `match_cnt` updates on the same edge as `q`.
- `armed` is registered and follows the FSM state.
- Back-to-back matches are possible in overlap mode. For example, with `pattern` all-ones, `q` stays high on every valid cycle once armed.
- Reset asserted mid-sequence: everything clears immediately, including a `q` pulse in progress, and partial history is discarded.

## Structure
- Package `seq_det_pkg` holds:
  - `typedef enum logic {FILL, ARMED} seq_state_t`.
  - Default parameter constants.
- One sub-module, `sat_counter`, parametrised by `CNT_W`. Its inputs are `inc` and `clr`, with clear-then-increment priority.
- `seq_detector` holds the shift register, fill counter, FSM and `q` register.

## Test plan
All scenarios use `WIDTH=4` unless noted.
- Overlap counting:
  - Stimulus: `pattern=4'b1011`, `overlap=1`, continuous valid stream `1,0,1,1,0,1,1`.
  - Response: `q` pulses after the 4th and 7th bits; `match_cnt=2`.
- Non-overlap counting:
  - Stimulus: same stream with `overlap=0`.
  - Response: a single `q` pulse after bit 4, `match_cnt=1`, and `armed` drops for 4 valid bits.
- Valid gaps:
  - Stimulus: `pattern=4'b1011`, bits `1,0,1,1` with `in_valid=0` for 3 cycles between each bit.
  - Response: one `q` pulse, one cycle after the final valid bit.
- Reset mid-stream:
  - Stimulus: after `1,0,1`, pulse `rst=0` for one cycle, then send `1`.
  - Response: no match, `armed=0`, `match_cnt` unchanged at 0. Then `0,1,1` → still no match until 4 post-reset bits form `1011`.
- Saturation and clear (`CNT_W=2`):
  - Stimulus: `pattern=4'b1111`, `overlap=1`, 10 valid ones.
  - Response: `q` high on 7 consecutive cycles and `match_cnt` saturates at 3.
  - Stimulus: `cnt_clr` on a matching cycle.
  - Response: `match_cnt=1`.
- Random soak:
  - Stimulus: 1000 random `in`/`in_valid` cycles, mixing both `overlap` values, against a reference model.
  - Response: `q` and `match_cnt` match the model cycle-exactly.
